// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the pipeline
// enable/flush bundle and the canned bundles each hazard response produces.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_bubble;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam pipe_ctl_t CTL_BRANCH = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctl_t CTL_LDUSE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // A taken branch squashes ID, so a load-use seen there is on the wrong path.
    function automatic pipe_ctl_t run_ctl(input logic branch, input logic load_use);
        if (branch)
            return CTL_BRANCH;
        else if (load_use)
            return CTL_LDUSE;
        else
            return CTL_RUN;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard sequencer.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
) ();
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              id_ex_memRead;
    logic [REG_AW-1:0] id_ex_rd;
    logic              ex_branch_taken;
    logic              ex_mem_memReq;
    logic              mem_ready;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_flush;
    logic              id_ex_we;
    logic              id_ex_flush;
    logic              ex_mem_we;
    logic              mem_wb_bubble;
    logic              mem_timeout_err;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_ex_memRead, id_ex_rd,
               ex_branch_taken, ex_mem_memReq, mem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_bubble, mem_timeout_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_ex_memRead, id_ex_rd,
               ex_branch_taken, ex_mem_memReq, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_bubble, mem_timeout_err
    );
endinterface

// File: rtl/hazard_ctrl_stats.sv
// Saturating stall/flush counter pair; only built with HAZARD_CTRL_STATS_EN.
`ifdef HAZARD_CTRL_STATS_EN
module hazard_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
        if (flush_inc && (flush_q != '1))
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule
`endif

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stalls, branch flushes, data-memory waits
// with timeout. Optional statistics counters under HAZARD_CTRL_STATS_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hif
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    pipe_ctl_t         ctl;
    logic              load_use;
    logic              mem_stall;

    assign load_use = hif.id_ex_memRead
                   && (hif.id_ex_rd != REG_AW'(REG_ZERO))
                   && ((hif.id_ex_rd == hif.id_rs)
                       || (hif.id_uses_rt && (hif.id_ex_rd == hif.id_rt)));
    assign mem_stall = hif.ex_mem_memReq && !hif.mem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        ctl        = CTL_IDLE;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctl        = CTL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    ctl = run_ctl(hif.ex_branch_taken, load_use);
                end
            end
            MEM_WAIT: begin
                if (hif.mem_ready) begin
                    ctl        = run_ctl(hif.ex_branch_taken, load_use);
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctl = CTL_FREEZE;
                    // Counter stops at MEM_TIMEOUT, so it can never wrap.
                    if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ERR:     ctl = CTL_FREEZE;
            default: state_d = RUN;
        endcase
        // Reset is asynchronous, so the outputs must go quiet without waiting for a clock.
        if (!rst_n)
            ctl = CTL_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hif.pc_we           = ctl.pc_we;
    assign hif.if_id_we        = ctl.if_id_we;
    assign hif.if_id_flush     = ctl.if_id_flush;
    assign hif.id_ex_we        = ctl.id_ex_we;
    assign hif.id_ex_flush     = ctl.id_ex_flush;
    assign hif.ex_mem_we       = ctl.ex_mem_we;
    assign hif.mem_wb_bubble   = ctl.mem_wb_bubble;
    assign hif.mem_timeout_err = err_q;

`ifdef HAZARD_CTRL_STATS_EN
    hazard_stats #(.CNT_W(CNT_W)) u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc    (!ctl.pc_we),
        .flush_inc    (ctl.if_id_flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4); expected output vectors are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hif ();

`ifdef HAZARD_CTRL_STATS_EN
    logic [2:0] stall_cycles, flush_count;
`endif

    hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_bubble, err}
    localparam logic [7:0] V_RST  = 8'b0000_0000;
    localparam logic [7:0] V_RUN  = 8'b1101_0100;
    localparam logic [7:0] V_LU   = 8'b0000_1100;
    localparam logic [7:0] V_BR   = 8'b1010_1100;
    localparam logic [7:0] V_FRZ  = 8'b0000_0010;
    localparam logic [7:0] V_ERR  = 8'b0000_0011;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic [7:0] obs;

    assign obs = {hif.pc_we, hif.if_id_we, hif.if_id_flush, hif.id_ex_we,
                  hif.id_ex_flush, hif.ex_mem_we, hif.mem_wb_bubble, hif.mem_timeout_err};

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mrd, input logic [4:0] rd, input logic br,
                         input logic req, input logic rdy);
        hif.id_rs           = rs;
        hif.id_rt           = rt;
        hif.id_uses_rt      = uses_rt;
        hif.id_ex_memRead   = mrd;
        hif.id_ex_rd        = rd;
        hif.ex_branch_taken = br;
        hif.ex_mem_memReq   = req;
        hif.mem_ready       = rdy;
    endtask

    task automatic compare(input logic [7:0] actual);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: got %b required an entry", actual);
            return;
        end
        e = sb.pop_front();
        assert (actual === e.exp) passed++;
        else $error("FAIL %s: got %b required %b", e.tag, actual, e.exp);
    endtask

    // Called just after a rising edge: queue expectation, sample mid-cycle, advance.
    task automatic step(input string tag, input logic [7:0] exp);
        sb.push_back('{tag, exp});
        @(negedge clk);
        compare(obs);
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_CTRL_STATS_EN
    task automatic check_stats(input string tag, input logic [2:0] st, input logic [2:0] fl);
        sb.push_back('{tag, {2'b00, st, fl}});
        compare({2'b00, stall_cycles, flush_count});
    endtask
`endif

    initial begin
        drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{"reset_outputs", V_RST});
        compare(obs);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("run_idle", V_RUN);
        // Load-use on rs, then the load moves on.
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        step("lu_rs", V_LU);
        drive(5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        step("lu_after", V_RUN);
        drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step("lu_rt", V_LU);
        drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step("no_lu_rt_unused", V_RUN);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("no_lu_r0", V_RUN);
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        step("br_over_lu", V_BR);

        // Memory wait: three frozen cycles (branch+hazard ignored), then ready.
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
        step("mw_1", V_FRZ);
        step("mw_2", V_FRZ);
        step("mw_3", V_FRZ);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        step("mw_ready", V_RUN);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("mw_back_run", V_RUN);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        step("mw2_1", V_FRZ);
        drive(5'd4, 5'd2, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1);
        step("mw2_ready_lu", V_LU);

        // Timeout: entry cycle plus four counted wait cycles, then sticky ERR.
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        step("to_entry", V_FRZ);
        for (int i = 1; i <= 4; i++)
            step($sformatf("to_wait_%0d", i), V_FRZ);
        step("to_err", V_ERR);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
        step("err_sticky_ready", V_ERR);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("err_sticky_idle", V_ERR);

        rst_n = 1'b0;
        #1;
        sb.push_back('{"reset_mid_err", V_RST});
        compare(obs);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("after_reset_run", V_RUN);

`ifdef HAZARD_CTRL_STATS_EN
        check_stats("stats_zero", 3'd0, 3'd0);
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        step("st_lu1", V_LU);
        step("st_lu2", V_LU);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step("st_br", V_BR);
        check_stats("stats_2_1", 3'd2, 3'd1);
        drive(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        repeat (8) step("st_lu_sat", V_LU);
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        repeat (8) step("st_br_sat", V_BR);
        check_stats("stats_sat", 3'd7, 3'd7);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
